// File: rtl/sigmoid_alu_neuron_sequencer_if.sv
// Bundle between the neuron sequencer, its requester, the group memories and the sigmoid ALU.
// master = environment side (requester + ALU), slave = the sequencer.
interface sigmoid_alu_neuron_sequencer_if #(
    parameter int GROUP_ADDR_W = 4,
    parameter int NEURON_W     = 4
);
    logic                    start;
    logic                    abort;
    logic [NEURON_W-1:0]     neuron_idx;
    logic [3:0]              alu_out;
    logic [15:0]             alu_accum;
    logic                    busy;
    logic                    done;
    logic [NEURON_W-1:0]     neuron_sel;
    logic [GROUP_ADDR_W-1:0] group_addr;
    logic                    rd_en;
    logic                    alu_clear;
    logic                    alu_accumulate;
    logic [3:0]              result;
    logic [15:0]             result_accum;

    modport master (
        output start, abort, neuron_idx, alu_out, alu_accum,
        input  busy, done, neuron_sel, group_addr, rd_en, alu_clear, alu_accumulate,
               result, result_accum
    );

    modport slave (
        input  start, abort, neuron_idx, alu_out, alu_accum,
        output busy, done, neuron_sel, group_addr, rd_en, alu_clear, alu_accumulate,
               result, result_accum
    );
endinterface

// File: rtl/sigmoid_alu_neuron_sequencer.sv
// Sequences one neuron evaluation: clear ALU, stream GROUPS address reads, let the
// registered 4-way sum drain into the accumulator, then capture sigma and the raw sum.
module sigmoid_alu_neuron_sequencer #(
    parameter int NUM_INPUTS   = 64,
    parameter int GROUP_ADDR_W = 4,
    parameter int NEURON_W     = 4
) (
    input  logic clk,
    input  logic n_rst,
    sigmoid_alu_neuron_sequencer_if.slave bus
);
    localparam int GROUPS = NUM_INPUTS / 4;
    localparam logic [GROUP_ADDR_W-1:0] LAST_GRP = GROUP_ADDR_W'(GROUPS - 1);

    if ((NUM_INPUTS % 4 != 0) || (NUM_INPUTS < 4) || ((1 << GROUP_ADDR_W) < GROUPS)) begin : g_bad_param
        $error("sigmoid_alu_neuron_sequencer: bad NUM_INPUTS / GROUP_ADDR_W");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FETCH   = 3'd2,
        DRAIN1  = 3'd3,
        DRAIN2  = 3'd4,
        CAPTURE = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [GROUP_ADDR_W-1:0] cnt_q, cnt_d;
    logic [NEURON_W-1:0]     nsel_q, nsel_d;
    logic [3:0]              res_q, res_d;
    logic [15:0]             res_acc_q, res_acc_d;
    logic                    done_q, done_d;
    // rd_en delayed twice: memory latency plus the ALU's registered group sum
    logic [1:0]              acc_pipe_q, acc_pipe_d;
    logic                    rd_en;

    assign rd_en = (state_q == FETCH);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nsel_q     <= '0;
            res_q      <= '0;
            res_acc_q  <= '0;
            done_q     <= 1'b0;
            acc_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nsel_q     <= nsel_d;
            res_q      <= res_d;
            res_acc_q  <= res_acc_d;
            done_q     <= done_d;
            acc_pipe_q <= acc_pipe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nsel_d     = nsel_q;
        res_d      = res_q;
        res_acc_d  = res_acc_q;
        done_d     = 1'b0;
        acc_pipe_d = {acc_pipe_q[0], rd_en};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nsel_d  = bus.neuron_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                // hold on the last group instead of wrapping the address
                if (cnt_q == LAST_GRP) state_d = DRAIN1;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            DRAIN1:  state_d = DRAIN2;
            DRAIN2:  state_d = CAPTURE;
            CAPTURE: begin
                res_d     = bus.alu_out;
                res_acc_d = bus.alu_accum;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // abort outranks everything; the ALU accumulator stays dirty until the next CLEAR
        if (bus.abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            acc_pipe_d = '0;
            done_d     = 1'b0;
            res_d      = res_q;
            res_acc_d  = res_acc_q;
        end
    end

    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.neuron_sel     = nsel_q;
    assign bus.group_addr     = cnt_q;
    assign bus.rd_en          = rd_en;
    assign bus.alu_clear      = (state_q == CLEAR);
    assign bus.alu_accumulate = acc_pipe_q[1];
    assign bus.result         = res_q;
    assign bus.result_accum   = res_acc_q;

    a_clr_acc_excl: assert property (@(posedge clk) disable iff (!n_rst)
        !(bus.alu_clear && bus.alu_accumulate));
endmodule

// File: doc/sigmoid_alu_neuron_sequencer.md
Name: sigmoid_alu_neuron_sequencer

Overview:
Controller that runs one full neuron evaluation on the sigmoid ALU datapath. It issues weight/input group read addresses to synchronous memories, which return data one cycle later straight to the ALU operand ports. It drives the ALU `clear` and `accumulate` strobes, aligned to the ALU's registered 4-way sum. It then captures the sigmoid output and raw accumulator for the requester, with a start/busy/done handshake.

Parameters:
NUM_INPUTS, 64, neuron fan-in; must be a multiple of 4; GROUPS = NUM_INPUTS/4 (localparam).
GROUP_ADDR_W, 4, width of group_addr; 2**GROUP_ADDR_W must be >= GROUPS.
NEURON_W, 4, width of the neuron index.

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  request evaluation; sampled only in IDLE
abort  in  1  cancel in-progress evaluation
neuron_idx  in  NEURON_W  neuron to evaluate, latched on accepted start
alu_out  in  4  sigmoid ALU out (u1.3 sigma)
alu_accum  in  16  sigmoid ALU accum_out
busy  out  1  high from the cycle after start acceptance through CAPTURE
done  out  1  one-cycle pulse; result valid
neuron_sel  out  NEURON_W  latched neuron index to weight/bias memories
group_addr  out  GROUP_ADDR_W  group read address (1-cycle read latency)
rd_en  out  1  group_addr valid this cycle
alu_clear  out  1  to ALU clear
alu_accumulate  out  1  to ALU accumulate
result  out  4  captured sigma
result_accum  out  16  captured accumulator

Behaviour:
- Reset (async, n_rst=0): state IDLE. busy, done, rd_en, alu_clear, alu_accumulate = 0. group_addr, neuron_sel, result, result_accum = 0. Accumulate pipeline cleared.
- States: IDLE, CLEAR, FETCH, DRAIN1, DRAIN2, CAPTURE.
- IDLE: when start=1, latch neuron_idx and go to CLEAR. start in any other state is ignored (not queued).
- CLEAR: alu_clear=1 for exactly one cycle; group counter reset to 0; go to FETCH.
- FETCH: rd_en=1, group_addr=counter. Counter increments each cycle. After the cycle with counter=GROUPS-1, go to DRAIN1. FETCH lasts exactly GROUPS cycles.
- Accumulate alignment: rd_en is delayed 2 cycles (two flops) to form alu_accumulate. Address at cycle t gives ALU operands at t+1, added_reg at t+2, and accumulate high during t+2.
- DRAIN1 and DRAIN2: rd_en=0; pipeline flushes the last two accumulates; one cycle each.
- CAPTURE: accumulator is final. Register result <= alu_out and result_accum <= alu_accum; go to IDLE. done=1 in the following cycle, which is IDLE.
- Timing with start accepted at cycle 0: CLEAR at cycle 1, FETCH at cycles 2..GROUPS+1, DRAIN at GROUPS+2 and GROUPS+3, CAPTURE at GROUPS+4, done at GROUPS+5.
- busy=1 in CLEAR through CAPTURE; busy=0 in the done cycle.
- A start in the done cycle is accepted; back-to-back evaluations are allowed.
- result and result_accum hold until the next CAPTURE; abort does not change them.
- abort (any non-IDLE state, highest priority over state progress):
  - Next state is IDLE; accumulate pipeline flops and rd_en are cleared in the same edge.
  - No done pulse.
  - The ALU accumulator is left dirty; the next run's CLEAR fixes it.
- abort in IDLE: no effect. abort and start together in IDLE: start wins.
- alu_clear and alu_accumulate are never high in the same cycle. Guaranteed because the first accumulate occurs in FETCH cycle 3.
- No arithmetic on data in this block; the counter saturates logically via the state transition, with no wrap.

Test Plan:
- Reset: hold n_rst=0 mid-FETCH (GROUPS=4) -> all outputs 0 immediately, state IDLE; after release, no done and no rd_en.
- NUM_INPUTS=16, start at cycle 0 -> alu_clear at cycle 1; rd_en with group_addr 0,1,2,3 at cycles 2-5; alu_accumulate at cycles 4-7; done at cycle 9 only.
- Positive saturation: all weights 4'b0001, inputs 4'b1000, bias 0 -> result_accum=128, result=4'b1000.
- Negative saturation: weights 4'b1111 (-1) -> result_accum=16'hFF80, result=0. Zero case: weights 0, bias 4'b1111 -> result_accum=0, result=4'b0010.
- Handshake: start pulsed during FETCH -> ignored. start in the done cycle -> CLEAR next cycle; second done exactly GROUPS+5 cycles after it.
- Abort in DRAIN1 -> IDLE next cycle, alu_accumulate 0 from then on, no done, result unchanged. A new start then yields the correct result after CLEAR.
